buscaminas_game_fsm: RTL

Core minesweeper game controller for the Buscaminas FPGA lab. It owns an 8x8 board: mine placement from an LFSR, cursor movement, reveal and flag actions, and neighbour-count computation. It produces the game_over and win flags consumed directly by the downstream game-over/7-segment display stage. It also drives the board bitmaps to the VGA/LED renderer. All action inputs are single-cycle pulses from the debounce stage upstream.

---
 rtl/buscaminas_pkg.sv | 42 ++++
 rtl/buscaminas_lfsr.sv | 22 ++
 rtl/buscaminas_game_fsm.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/buscaminas_pkg.sv
// Shared types, board geometry and helpers for the Buscaminas game core.
package buscaminas_pkg;

    localparam int unsigned BOARD_ROWS = 8;
    localparam int unsigned BOARD_COLS = 8;
    localparam int unsigned CELLS      = BOARD_ROWS * BOARD_COLS;
    localparam int unsigned POS_W      = 3;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned LFSR_W     = 16;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {IDLE, PLACE, PLAY, COUNT, LOSE, WIN} state_t;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } nb_off_t;

    // Neighbour visit order: NW, N, NE, W, E, SW, S, SE
    function automatic nb_off_t nb_off(input logic [2:0] k);
        nb_off_t o;
        case (k)
            3'd0:    o = '{dr: -2'sd1, dc: -2'sd1};
            3'd1:    o = '{dr: -2'sd1, dc:  2'sd0};
            3'd2:    o = '{dr: -2'sd1, dc:  2'sd1};
            3'd3:    o = '{dr:  2'sd0, dc: -2'sd1};
            3'd4:    o = '{dr:  2'sd0, dc:  2'sd1};
            3'd5:    o = '{dr:  2'sd1, dc: -2'sd1};
            3'd6:    o = '{dr:  2'sd1, dc:  2'sd0};
            default: o = '{dr:  2'sd1, dc:  2'sd1};
        endcase
        return o;
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [POS_W-1:0] row,
                                                  input logic [POS_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/buscaminas_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low OUT_W bits.
module buscaminas_lfsr
    import buscaminas_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int unsigned       OUT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] rnd
);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= SEED;
        else       lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/buscaminas_game_fsm.sv
// Minesweeper game controller: mine placement, cursor, reveal/flag and
// sequential neighbour counting over an 8x8 board.
module buscaminas_game_fsm
    import buscaminas_pkg::*;
#(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned NUM_MINES = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mv_up,
    input  logic        mv_down,
    input  logic        mv_left,
    input  logic        mv_right,
    input  logic        reveal,
    input  logic        flag,
    output logic [2:0]  cursor_row,
    output logic [2:0]  cursor_col,
    output logic [63:0] revealed,
    output logic [63:0] flagged,
    output logic [63:0] mine_map,
    output logic [3:0]  cell_count,
    output logic [3:0]  mines_left,
    output logic        busy,
    output logic        game_over,
    output logic        win
);

    localparam int unsigned     FCNT_W      = 7;
    localparam logic [POS_W-1:0] ROW_MAX    = POS_W'(ROWS - 1);
    localparam logic [POS_W-1:0] COL_MAX    = POS_W'(COLS - 1);
    localparam logic [IDX_W-1:0] LAST_MINE  = IDX_W'(NUM_MINES - 1);
    localparam logic [IDX_W-1:0] SAFE_TOTAL = IDX_W'(CELLS - NUM_MINES);

    state_t              state, state_n;
    logic [IDX_W-1:0]    place_idx, cur, placed, safe_cnt;
    logic [FCNT_W-1:0]   flag_cnt;
    logic [2:0]          step;
    logic [POS_W-1:0]    cnt_row, cnt_col;
    logic [3:0]          acc;
    nb_off_t             off;
    logic [4:0]          nr, nc;
    logic                term_c, reveal_ok_c;
    logic                clear_c, place_c, reveal_c, flag_c;
    logic                up_c, down_c, left_c, right_c, last_step_c;

    buscaminas_lfsr #(.SEED(LFSR_SEED), .OUT_W(IDX_W)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .rnd   (place_idx)
    );

    assign cur         = cell_idx(cursor_row, cursor_col);
    assign reveal_ok_c = !flagged[cur] && !revealed[cur];
    assign mines_left  = (flag_cnt >= FCNT_W'(NUM_MINES)) ? 4'd0
                                                           : 4'(FCNT_W'(NUM_MINES) - flag_cnt);

    // Current neighbour term; off-board coordinates wrap to >= 8 and are masked
    always_comb begin
        off    = nb_off(step);
        nr     = {2'b00, cnt_row} + {{3{off.dr[1]}}, off.dr};
        nc     = {2'b00, cnt_col} + {{3{off.dc[1]}}, off.dc};
        term_c = (nr <= 5'(ROW_MAX)) && (nc <= 5'(COL_MAX))
                 && mine_map[cell_idx(nr[2:0], nc[2:0])];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, LOSE, WIN: if (start) state_n = PLACE;
            PLACE:           if (place_c && placed == LAST_MINE) state_n = PLAY;
            PLAY: begin
                if (clear_c)       state_n = PLACE;
                else if (reveal_c) state_n = mine_map[cur] ? LOSE : COUNT;
            end
            COUNT: if (last_step_c)
                       state_n = (IDX_W'(safe_cnt + IDX_W'(1)) == SAFE_TOTAL) ? WIN : PLAY;
            default: state_n = IDLE;
        endcase
    end

    // Action decode: one action per cycle, reveal > flag > up > down > left > right
    always_comb begin
        clear_c     = 1'b0;
        place_c     = 1'b0;
        reveal_c    = 1'b0;
        flag_c      = 1'b0;
        up_c        = 1'b0;
        down_c      = 1'b0;
        left_c      = 1'b0;
        right_c     = 1'b0;
        last_step_c = 1'b0;
        case (state)
            IDLE, LOSE, WIN: clear_c = start;
            PLACE:           place_c = !mine_map[place_idx];
            PLAY: begin
                if (start)         clear_c  = 1'b1;
                else if (reveal)   reveal_c = reveal_ok_c;
                else if (flag)     flag_c   = !revealed[cur];
                else if (mv_up)    up_c     = 1'b1;
                else if (mv_down)  down_c   = 1'b1;
                else if (mv_left)  left_c   = 1'b1;
                else if (mv_right) right_c  = 1'b1;
            end
            COUNT:   last_step_c = (step == 3'd7);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cursor_row <= '0;
            cursor_col <= '0;
            revealed   <= '0;
            flagged    <= '0;
            mine_map   <= '0;
            cell_count <= '0;
            flag_cnt   <= '0;
            placed     <= '0;
            safe_cnt   <= '0;
            step       <= '0;
            cnt_row    <= '0;
            cnt_col    <= '0;
            acc        <= '0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            win        <= 1'b0;
        end else begin
            if (clear_c) begin
                cursor_row <= '0;
                cursor_col <= '0;
                revealed   <= '0;
                flagged    <= '0;
                mine_map   <= '0;
                cell_count <= '0;
                flag_cnt   <= '0;
                placed     <= '0;
                safe_cnt   <= '0;
            end
            if (place_c) begin
                mine_map[place_idx] <= 1'b1;
                placed              <= placed + IDX_W'(1);
            end
            if (reveal_c) begin
                revealed[cur] <= 1'b1;
                cnt_row       <= cursor_row;
                cnt_col       <= cursor_col;
                acc           <= '0;
                step          <= '0;
            end
            if (flag_c) begin
                flagged[cur] <= !flagged[cur];
                flag_cnt     <= flagged[cur] ? flag_cnt - FCNT_W'(1) : flag_cnt + FCNT_W'(1);
            end
            if (up_c && cursor_row != '0)         cursor_row <= cursor_row - POS_W'(1);
            if (down_c && cursor_row != ROW_MAX)  cursor_row <= cursor_row + POS_W'(1);
            if (left_c && cursor_col != '0)       cursor_col <= cursor_col - POS_W'(1);
            if (right_c && cursor_col != COL_MAX) cursor_col <= cursor_col + POS_W'(1);
            if (state == COUNT) begin
                acc  <= acc + 4'(term_c);
                step <= step + 3'd1;
                if (last_step_c) begin
                    cell_count <= acc + 4'(term_c);
                    safe_cnt   <= safe_cnt + IDX_W'(1);
                end
            end
            busy      <= (state_n == PLACE) || (state_n == COUNT);
            game_over <= (state_n == LOSE);
            win       <= (state_n == WIN);
        end
    end

endmodule
